// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared instruction-format constants and types for the CPU front end
//  Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

   localparam int PC_W       = 16;
   localparam int INS_LEN_HI = 15;
   localparam int INS_LEN_LO = 14;

   localparam logic [1:0] LEN_ONE_A = 2'b00;
   localparam logic [1:0] LEN_ONE_B = 2'b01;
   localparam logic [1:0] LEN_TWO   = 2'b10;
   localparam logic [1:0] LEN_ILL   = 2'b11;

   // One buffered ROM word together with the address it was fetched from
   typedef struct packed {
      logic [PC_W-1:0] word;
      logic [PC_W-1:0] addr;
   } fifo_entry_t;

   // Extract the instruction length field from an opcode word
   function automatic logic [1:0] ins_len(input logic [PC_W-1:0] word);
      return word[INS_LEN_HI:INS_LEN_LO];
   endfunction

endpackage
`default_nettype wire

// File: rtl/ins_word_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ins_word_fifo
//  Purpose  : Word/address FIFO with single push, 0/1/2 pop and sync clear;
//             exposes the head entry and the word behind it
//  Revision : 1.0  initial release
// ============================================================================
module ins_word_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  fifo_entry_t              push_data,
   input  logic [1:0]               pop,
   output fifo_entry_t              head,
   output logic [PC_W-1:0]          next_word,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int c_aw = $clog2(DEPTH);
   localparam int c_cw = c_aw + 1;
   localparam logic [c_aw-1:0] c_one = 1;

   fifo_entry_t       r_mem [DEPTH];
   logic [c_aw-1:0]   r_rd_ptr;
   logic [c_aw-1:0]   r_wr_ptr;
   logic [c_cw-1:0]   r_count;
   logic [c_aw-1:0]   w_rd_nxt;

   assign w_rd_nxt  = r_rd_ptr + c_one;
   assign head      = r_mem[r_rd_ptr];
   assign next_word = r_mem[w_rd_nxt].word;
   assign count     = r_count;

   // Storage write; contents need no reset because count qualifies every read
   always_ff @(posedge clk) begin
      if (push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy update; clear and reset both empty the queue
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) begin
            r_wr_ptr <= r_wr_ptr + c_one;
         end
         r_rd_ptr <= r_rd_ptr + c_aw'(pop);
         r_count  <= r_count + c_cw'(push) - c_cw'(pop);
      end
   end

endmodule
`default_nettype wire

// File: rtl/ins_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : ins_fetch_unit
//  Purpose  : Instruction fetch front end: issues ROM reads with credit-based
//             flow control, buffers returned words and assembles 1/2-word
//             instructions for the decoder with a valid/ready handshake
//  Revision : 1.0  initial release
// ============================================================================
module ins_fetch_unit
   import cpu_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic              rom_rd,
   output logic [PC_W-1:0]   rom_addr,
   input  logic [PC_W-1:0]   rom_data,
   input  logic              pc_load,
   input  logic [PC_W-1:0]   pc_target,
   output logic              ins_valid,
   input  logic              ins_ready,
   output logic [PC_W-1:0]   ins_word0,
   output logic [PC_W-1:0]   ins_word1,
   output logic              ins_two,
   output logic              ins_ill,
   output logic [PC_W-1:0]   ins_pc
);

   localparam int              c_cw    = $clog2(DEPTH) + 1;
   localparam logic [c_cw:0]   c_depth = (c_cw + 1)'(DEPTH);

   logic [PC_W-1:0]   r_fetch_pc;
   logic              r_pend;
   logic [PC_W-1:0]   r_pend_addr;

   logic              w_issue;
   logic              w_push;
   logic [1:0]        w_pop;
   logic [c_cw-1:0]   w_count;
   fifo_entry_t       w_head;
   fifo_entry_t       w_push_data;
   logic [PC_W-1:0]   w_next_word;
   logic [1:0]        w_len;

   // The in-flight response holds a credit so a full FIFO can never overflow;
   // same-cycle pops are deliberately not credited.
   assign w_issue  = en & ~pc_load & ~rst &
                     (({1'b0, w_count} + {{c_cw{1'b0}}, r_pend}) < c_depth);
   assign rom_rd   = w_issue;
   assign rom_addr = r_fetch_pc;

   // A redirect edge drops the pending flag and clears the FIFO, so a response
   // arriving in the redirect cycle is never written.
   assign w_push      = r_pend & ~pc_load;
   assign w_push_data = '{word: rom_data, addr: r_pend_addr};

   // Fetch PC, pending-response flag and the address of the pending response
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc  <= RESET_PC;
         r_pend      <= 1'b0;
         r_pend_addr <= '0;
      end else if (pc_load) begin
         r_fetch_pc  <= pc_target;
         r_pend      <= 1'b0;
      end else begin
         r_pend <= w_issue;
         if (w_issue) begin
            r_fetch_pc  <= r_fetch_pc + 16'd1;
            r_pend_addr <= r_fetch_pc;
         end
      end
   end

   ins_word_fifo #(
      .DEPTH     (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (pc_load),
      .push      (w_push),
      .push_data (w_push_data),
      .pop       (w_pop),
      .head      (w_head),
      .next_word (w_next_word),
      .count     (w_count)
   );

   assign w_len = ins_len(w_head.word);

   // Head assembly: a two-word head waits until its second word is buffered
   always_comb begin
      ins_valid = 1'b0;
      ins_word0 = '0;
      ins_word1 = '0;
      ins_two   = 1'b0;
      ins_ill   = 1'b0;
      ins_pc    = '0;
      if (!pc_load) begin
         if (w_len == LEN_TWO) begin
            ins_valid = (w_count >= c_cw'(2));
         end else begin
            ins_valid = (w_count >= c_cw'(1));
         end
      end
      if (ins_valid) begin
         ins_word0 = w_head.word;
         ins_pc    = w_head.addr;
         ins_two   = (w_len == LEN_TWO);
         ins_ill   = (w_len == LEN_ILL);
         ins_word1 = (w_len == LEN_TWO) ? w_next_word : '0;
      end
   end

   // Accepted instruction consumes one or two FIFO words
   always_comb begin
      w_pop = 2'd0;
      if (ins_valid && ins_ready) begin
         w_pop = ins_two ? 2'd2 : 2'd1;
      end
   end

endmodule
`default_nettype wire

// File: doc/ins_fetch_unit.md
Name: ins_fetch_unit

Overview:
- Instruction fetch front-end between the instruction ROM and the instruction splitter/decoder.
- Drives ROM addresses from its own fetch PC and buffers the returned 16-bit words in a small FIFO.
- Assembles one- or two-word instructions and presents them to the decoder with a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes all buffered and in-flight words.

Parameters:
- DEPTH, 4, FIFO depth in words; power of 2, minimum 2.
- RESET_PC, 16'h0000, fetch PC loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  fetch enable; 0 suppresses new ROM requests; handshake and draining continue.
- rom_rd  out  1  ROM read strobe.
- rom_addr  out  16  ROM word address (= fetch PC).
- rom_data  in  16  ROM read data, valid exactly 1 cycle after rom_rd.
- pc_load  in  1  redirect request.
- pc_target  in  16  redirect address.
- ins_valid  out  1  instruction available.
- ins_ready  in  1  decoder accepts.
- ins_word0  out  16  opcode word.
- ins_word1  out  16  second word (immediate/direct address); 0 for one-word instructions.
- ins_two  out  1  instruction is two words.
- ins_ill  out  1  length field illegal.
- ins_pc  out  16  address of ins_word0.

Behaviour:
- Priority at each edge: rst > pc_load > normal operation.
- Reset:
  - fetch_pc = RESET_PC; FIFO count = 0; pending-response flag = 0.
  - rom_rd = 0, ins_valid = 0.
  - ins_word0, ins_word1 and ins_pc = 0; ins_two and ins_ill = 0.
- Length field is word[15:14]:
  - 2'b10 = two-word.
  - 2'b00 and 2'b01 = one-word.
  - 2'b11 = one-word with ins_ill=1.
- Issue rule (combinational):
  - rom_rd = en & !pc_load & !rst & (count + pend < DEPTH).
  - Pops in the same cycle are not credited.
  - On an issue edge: pend <= 1, fetch_pc <= fetch_pc + 1, wrapping 16'hFFFF -> 16'h0000.
- Response:
  - The cycle after an issue, if the response has not been killed, rom_data is written to the FIFO tail together with its address.
  - pend clears unless a new issue occurs.
- Head assembly, with the head word of length field L:
  - ins_valid = !pc_load & ((count >= 1 & L != 2'b10) | (count >= 2 & L == 2'b10)).
  - A two-word head with count == 1 waits and ins_valid stays 0.
- Output values:
  - While ins_valid = 0, ins_word0, ins_word1, ins_pc, ins_two and ins_ill are driven 0.
  - While ins_valid = 1, ins_word0 = head word and ins_pc = head address; ins_word1 = next FIFO word if ins_two, else 0.
- Handshake:
  - Pop on ins_valid & ins_ready: 1 word, or 2 words if ins_two.
  - Outputs are held stable while ins_valid & !ins_ready.
  - Push and pop in the same cycle are allowed; count changes by pushes minus pops.
- Redirect: on a pc_load edge:
  - FIFO is emptied and count = 0.
  - Any outstanding ROM response is killed; its data is not written on the following edge.
  - fetch_pc = pc_target.
  - The first request to pc_target is issued in the cycle after pc_load.
- Latency: rom_rd is asserted in the first cycle with rst low. ins_valid for a one-word instruction rises 2 cycles after rst deasserts. The same 2 cycles apply after pc_load deasserts.
- Full FIFO: no issue. A full FIFO never overflows, since credit counts the pending response.
- en low: the in-flight response still completes and is written to the FIFO.
- rst asserted mid-operation: takes effect at the next edge and discards everything.

Decomposition:
- Shared package (cpu_pkg) holds:
  - length-field constants LEN_ONE_A = 2'b00, LEN_ONE_B = 2'b01, LEN_TWO = 2'b10, LEN_ILL = 2'b11.
  - field positions INS_LEN_HI = 15, INS_LEN_LO = 14.
  - PC_W = 16.
- Sub-module ins_word_fifo:
  - DEPTH x 32 storage (word + address), synchronous clear, single push, pop of 0/1/2.
  - Outputs: head, head+1, count.
- Top level holds the issue/credit logic, the kill flag and head assembly.

Test Plan:
- Reset, ROM words 0x0000 -> 16'h1234, 0x0001 -> 16'h0567, ins_ready=1 -> rom_addr 0,1,2,... per cycle; ins_valid at cycle 2 with word0=16'h1234, ins_pc=0; next cycle word0=16'h0567, ins_pc=1.
- Two-word instruction: ROM[0]=16'h8A01, ROM[1]=16'h00FF -> single ins_valid with ins_two=1, word0=16'h8A01, word1=16'h00FF, ins_pc=0; next instruction has ins_pc=2.
- Backpressure: ins_ready=0 for 10 cycles from reset -> rom_rd stops after 4 issues, count=4, outputs stable at ROM[0]; release -> words popped in order with no gaps or duplicates.
- Redirect: pc_load=1 with pc_target=16'h0040 while a response is in flight -> the stale word is never presented; next ins_valid has ins_pc=16'h0040, 2 cycles after pc_load falls.
- Wrap and illegal: pc_target=16'hFFFF, ROM[FFFF]=16'hC000 -> ins_ill=1 with ins_pc=16'hFFFF; then rom_addr=16'h0000.
- en=0 after first issue -> exactly one word is buffered and presented; no further rom_rd until en=1.
